// File: rtl/crossbar_allocator_pkg.sv
// rtl/crossbar_allocator_pkg.sv - shared width helper and field-slicing macro for the crossbar blocks
`ifndef CROSSBAR_ALLOCATOR_PKG_SV
`define CROSSBAR_ALLOCATOR_PKG_SV

// Part-select for field idx of width w inside a flat concatenated bus.
`define CA_FIELD(idx, w) ((idx)*(w)) +: (w)

package crossbar_allocator_pkg;

  // Smallest port count that still needs a one-bit index.
  localparam int CA_MIN_PORTS = 2;

  // Select/dest field width; a degenerate N still gets one bit so buses never collapse.
  function automatic int sw_of(input int n);
    return (n < CA_MIN_PORTS) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/crossbar_allocator_rr_arbiter.sv
// rtl/crossbar_allocator_rr_arbiter.sv - per-output round-robin arbiter with grant lock
module crossbar_allocator_rr_arbiter
  import crossbar_allocator_pkg::*;
#(
  parameter int N  = 3,
  parameter int SW = sw_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          lock,
  input  logic [SW-1:0] lock_idx,
  output logic [SW-1:0] grant,
  output logic          valid
);

  logic found;

  assign valid = |req;

  // Cyclic scan from ptr; a held lock overrides so a stalled output keeps its source.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant = SW'(idx);
        found = 1'b1;
      end
    end
    if (lock) begin
      grant = lock_idx;
    end
    if (!valid) begin
      grant = '0;
    end
  end

endmodule

// File: rtl/crossbar_allocator.sv
// rtl/crossbar_allocator.sv - input holding slots, per-output arbitration and crossbar control
module crossbar_allocator
  import crossbar_allocator_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int WIDTH = 8,
  localparam int SW    = sw_of(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*SW-1:0]      in_dest,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N*WIDTH-1:0]   xbar_data,
  output logic [N*SW-1:0]      xbar_select,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N-1:0]         drop_err
);

  logic [N-1:0]          hold_valid_q, hold_valid_d;
  logic [N-1:0][SW-1:0]  hold_dest_q, hold_dest_d;
  logic [N*WIDTH-1:0]    hold_data_q, hold_data_d;
  logic [N-1:0][SW-1:0]  rr_q, rr_d;
  logic [N-1:0]          lock_q, lock_d;
  logic [N-1:0][SW-1:0]  lock_idx_q, lock_idx_d;
  logic [N-1:0]          drop_err_q, drop_err_d;

  logic [N-1:0][N-1:0]   req;
  logic [N-1:0][SW-1:0]  grant;
  logic [N-1:0]          any_valid;
  logic [N-1:0]          fire;
  logic [N-1:0]          depart;
  logic [N-1:0]          accept;
  logic [N-1:0]          dest_ok;

  // Per-output request vectors from the held destinations.
  always_comb begin
    req = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        req[o][i] = hold_valid_q[i] && (hold_dest_q[i] == SW'(o));
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_arb
      crossbar_allocator_rr_arbiter #(
        .N  (N),
        .SW (SW)
      ) u_arb (
        .req      (req[g]),
        .ptr      (rr_q[g]),
        .lock     (lock_q[g]),
        .lock_idx (lock_idx_q[g]),
        .grant    (grant[g]),
        .valid    (any_valid[g])
      );
    end
  endgenerate

  assign out_valid = any_valid;
  assign fire      = any_valid & out_ready;
  assign xbar_data = hold_data_q;
  assign drop_err  = drop_err_q;

  // Flatten grants onto the select bus (arbiter already forces 0 when idle).
  always_comb begin
    xbar_select = '0;
    for (int o = 0; o < N; o++) begin
      xbar_select[`CA_FIELD(o, SW)] = grant[o];
    end
  end

  // A slot departs when the output it targets fires with it as the grant.
  always_comb begin
    depart = '0;
    for (int i = 0; i < N; i++) begin
      for (int o = 0; o < N; o++) begin
        if (fire[o] && (grant[o] == SW'(i))) begin
          depart[i] = 1'b1;
        end
      end
    end
  end

  assign in_ready = ~hold_valid_q | depart;
  assign accept   = in_valid & in_ready;

  // Out-of-range destinations are rejected at the door rather than stored.
  always_comb begin
    dest_ok = '0;
    for (int i = 0; i < N; i++) begin
      dest_ok[i] = ({1'b0, in_dest[`CA_FIELD(i, SW)]} < (SW+1)'(N));
    end
  end

  // Slot refill/drain, round-robin advance and stall lock bookkeeping.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_dest_d  = hold_dest_q;
    hold_data_d  = hold_data_q;
    rr_d         = rr_q;
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    drop_err_d   = '0;
    for (int i = 0; i < N; i++) begin
      if (accept[i] && dest_ok[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_dest_d[i]  = in_dest[`CA_FIELD(i, SW)];
        hold_data_d[`CA_FIELD(i, WIDTH)] = in_data[`CA_FIELD(i, WIDTH)];
      end else if (depart[i]) begin
        hold_valid_d[i] = 1'b0;
      end
      drop_err_d[i] = accept[i] && !dest_ok[i];
    end
    for (int o = 0; o < N; o++) begin
      if (fire[o]) begin
        rr_d[o]   = (int'(grant[o]) == N - 1) ? '0 : grant[o] + SW'(1);
        lock_d[o] = 1'b0;
      end else if (any_valid[o]) begin
        lock_d[o]     = 1'b1;
        lock_idx_d[o] = grant[o];
      end
    end
  end

  // State registers; reset discards any held words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_dest_q  <= '0;
      hold_data_q  <= '0;
      rr_q         <= '0;
      lock_q       <= '0;
      lock_idx_q   <= '0;
      drop_err_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_dest_q  <= hold_dest_d;
      hold_data_q  <= hold_data_d;
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      lock_idx_q   <= lock_idx_d;
      drop_err_q   <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_crossbar_allocator.sv
// tb/tb_crossbar_allocator.sv - directed self-checking bench for crossbar_allocator
module tb_crossbar_allocator;

  localparam int N     = 3;
  localparam int WIDTH = 8;
  localparam int SW    = 2;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*SW-1:0]      in_dest;
  logic [N*WIDTH-1:0]   in_data;
  logic [N*WIDTH-1:0]   xbar_data;
  logic [N*SW-1:0]      xbar_select;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N-1:0]         drop_err;

  int tests_run;
  int tests_failed;

  crossbar_allocator #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_data     (in_data),
    .xbar_data   (xbar_data),
    .xbar_select (xbar_select),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drop_err    (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = '0;
    in_dest   = '0;
    in_data   = '0;
    out_ready = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [N*WIDTH-1:0] exp_data;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = '0;
    in_dest      = '0;
    in_data      = '0;
    out_ready    = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h7);
    check("rst_select", 32'(xbar_select), 32'h0);
    check("rst_data", 32'(xbar_data), 32'h0);
    check("rst_drop", 32'(drop_err), 32'h0);

    // 1. Reset mid-transfer
    in_valid = 3'b001; in_dest = 6'b000010; in_data = 24'h000011; out_ready = 3'b000;
    step();
    in_valid = '0;
    check("t1_held_valid", 32'(out_valid), 32'h4);
    check("t1_held_ready", 32'(in_ready), 32'h6);
    rst = 1'b1;
    #1;
    check("t1_async_valid", 32'(out_valid), 32'h0);
    check("t1_async_select", 32'(xbar_select), 32'h0);
    check("t1_async_ready", 32'(in_ready), 32'h7);
    #2;
    rst = 1'b0;
    out_ready = 3'b111;
    step();
    check("t1_no_deliver_a", 32'(out_valid), 32'h0);
    step();
    check("t1_no_deliver_b", 32'(out_valid), 32'h0);

    // 2. Single transfer
    do_reset();
    in_valid = 3'b001; in_dest = 6'b000010; in_data = 24'h0000A5; out_ready = 3'b100;
    check("t2_pre_valid", 32'(out_valid), 32'h0);
    step();
    in_valid = '0;
    check("t2_valid", 32'(out_valid), 32'h4);
    check("t2_select", 32'(xbar_select), 32'h0);
    check("t2_data", 32'(xbar_data[7:0]), 32'hA5);
    check("t2_ready0", 32'(in_ready[0]), 32'h1);
    step();
    check("t2_drained", 32'(out_valid), 32'h0);

    // 3. Contention on output 1
    do_reset();
    in_valid = 3'b111; in_dest = 6'b010101; in_data = 24'h302010; out_ready = 3'b010;
    step();
    in_valid = '0;
    check("t3_valid", 32'(out_valid), 32'h2);
    check("t3_grant_a", 32'(xbar_select[3:2]), 32'h0);
    check("t3_ready_a", 32'(in_ready), 32'h1);
    step();
    check("t3_grant_b", 32'(xbar_select[3:2]), 32'h1);
    step();
    check("t3_grant_c", 32'(xbar_select[3:2]), 32'h2);
    check("t3_data_c", 32'(xbar_data[23:16]), 32'h30);
    step();
    check("t3_idle", 32'(out_valid), 32'h0);
    in_valid = 3'b101;
    step();
    in_valid = '0;
    check("t3_reoffer_a", 32'(xbar_select[3:2]), 32'h0);
    step();
    check("t3_reoffer_b", 32'(xbar_select[3:2]), 32'h2);
    step();
    check("t3_reoffer_idle", 32'(out_valid), 32'h0);

    // 4. Backpressure lock on output 0
    do_reset();
    in_valid = 3'b010; in_dest = 6'b000000; in_data = 24'h004200; out_ready = 3'b000;
    step();
    check("t4_stall1_valid", 32'(out_valid), 32'h1);
    check("t4_stall1_sel", 32'(xbar_select[1:0]), 32'h1);
    check("t4_stall1_data", 32'(xbar_data[15:8]), 32'h42);
    in_valid = 3'b001; in_data = 24'h004224;
    step();
    in_valid = '0;
    check("t4_stall2_sel", 32'(xbar_select[1:0]), 32'h1);
    step();
    check("t4_stall3_sel", 32'(xbar_select[1:0]), 32'h1);
    out_ready = 3'b001;
    #1;
    check("t4_release_sel", 32'(xbar_select[1:0]), 32'h1);
    step();
    check("t4_next_valid", 32'(out_valid), 32'h1);
    check("t4_next_sel", 32'(xbar_select[1:0]), 32'h0);
    check("t4_next_data", 32'(xbar_data[7:0]), 32'h24);
    step();
    check("t4_idle", 32'(out_valid), 32'h0);

    // 5. Invalid destination
    do_reset();
    in_valid = 3'b100; in_dest = 6'b110000; in_data = 24'h770000; out_ready = 3'b111;
    #1;
    check("t5_ready_pre", 32'(in_ready[2]), 32'h1);
    step();
    in_valid = '0;
    check("t5_drop", 32'(drop_err), 32'h4);
    check("t5_no_valid", 32'(out_valid), 32'h0);
    check("t5_ready", 32'(in_ready), 32'h7);
    step();
    check("t5_drop_clear", 32'(drop_err), 32'h0);

    // 6. Permutation streaming 0->1, 1->2, 2->0
    do_reset();
    in_valid = 3'b111; in_dest = 6'b001001; out_ready = 3'b111;
    for (int c = 0; c < 20; c++) begin
      exp_data = {8'(c*3 + 2), 8'(c*3 + 1), 8'(c*3)};
      in_data = exp_data;
      step();
      check($sformatf("t6_valid_%0d", c), 32'(out_valid), 32'h7);
      check($sformatf("t6_sel_%0d", c), 32'(xbar_select), 32'b010010);
      check($sformatf("t6_data_%0d", c), 32'(xbar_data), 32'(exp_data));
      check($sformatf("t6_ready_%0d", c), 32'(in_ready), 32'h7);
    end
    in_valid = '0;
    step();
    check("t6_drained", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
